// File: rtl/move_input_conditioner.sv
// Turns five raw buttons into one-cycle move codes and placement pulses (sync, debounce, rise detect, lockout).
// Define MOVE_INPUT_AUTO_REPEAT_EN to compile in held-direction auto-repeat; default build has no repeat timers.
module move_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_CYCLES   = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_right,
    input  logic       key_left,
    input  logic       key_confirm,
    input  logic       game_over,
    output logic [2:0] dir,
    output logic       confirm
);

    localparam int unsigned NUM_KEYS    = 5;
    localparam int unsigned NUM_DIRS    = 4;
    localparam int unsigned CNT_W       = 20;
    localparam int unsigned DEB_MAX     = 1048575;
    localparam int unsigned RPT_MAX     = 16777215;

    localparam int unsigned KEY_UP      = 0;
    localparam int unsigned KEY_DOWN    = 1;
    localparam int unsigned KEY_RIGHT   = 2;
    localparam int unsigned KEY_LEFT    = 3;
    localparam int unsigned KEY_CONFIRM = 4;

    localparam logic [2:0] DIR_IDLE  = 3'b000;
    localparam logic [2:0] DIR_UP    = 3'b001;
    localparam logic [2:0] DIR_DOWN  = 3'b010;
    localparam logic [2:0] DIR_RIGHT = 3'b011;
    localparam logic [2:0] DIR_LEFT  = 3'b100;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Out-of-range parameters would silently truncate the counters.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > DEB_MAX ||
        REPEAT_CYCLES < 2 || REPEAT_CYCLES > RPT_MAX) begin : g_bad_cfg
        $error("move_input_conditioner: DEBOUNCE_CYCLES or REPEAT_CYCLES out of range");
    end

    logic [NUM_KEYS-1:0] key_raw_c;
    logic [NUM_KEYS-1:0] sync_q1;
    logic [NUM_KEYS-1:0] sync_q2;
    logic [NUM_KEYS-1:0] stable_q;
    logic [CNT_W-1:0]    deb_cnt_q [NUM_KEYS];
    logic [NUM_KEYS-1:0] deb_done_c;
    logic [NUM_KEYS-1:0] rise_c;
    logic [NUM_KEYS-1:0] evt_next_c;
    logic [NUM_KEYS-1:0] evt_q;
    logic [2:0]          dir_next_c;
    logic                confirm_next_c;

    always_comb begin
        key_raw_c              = '0;
        key_raw_c[KEY_UP]      = key_up;
        key_raw_c[KEY_DOWN]    = key_down;
        key_raw_c[KEY_RIGHT]   = key_right;
        key_raw_c[KEY_LEFT]    = key_left;
        key_raw_c[KEY_CONFIRM] = key_confirm;
    end

    // A key is accepted once its synchronized level has differed from stable for DEBOUNCE_CYCLES edges.
    always_comb begin
        deb_done_c = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            deb_done_c[i] = (sync_q2[i] != stable_q[i]) && (deb_cnt_q[i] == DEB_LAST);
        end
    end

    assign rise_c = deb_done_c & ~stable_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1  <= '0;
            sync_q2  <= '0;
            stable_q <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync_q1 <= key_raw_c;
            sync_q2 <= sync_q1;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (sync_q2[i] == stable_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_done_c[i]) begin
                    deb_cnt_q[i] <= '0;
                    stable_q[i]  <= ~stable_q[i];
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef MOVE_INPUT_AUTO_REPEAT_EN
    localparam int unsigned RPT_W = 24;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0]    rpt_cnt_q [NUM_DIRS];
    logic [NUM_DIRS-1:0] rpt_fire_c;

    // Each direction counts edges since its last event while its stable level is high.
    always_comb begin
        rpt_fire_c = '0;
        for (int i = 0; i < NUM_DIRS; i++) begin
            rpt_fire_c[i] = stable_q[i] && (rpt_cnt_q[i] == RPT_LAST);
        end
    end

    always_comb begin
        evt_next_c                 = rise_c;
        evt_next_c[NUM_DIRS-1:0]   = rise_c[NUM_DIRS-1:0] | rpt_fire_c;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIRS; i++) begin
                rpt_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DIRS; i++) begin
                if (!stable_q[i] || evt_next_c[i]) begin
                    rpt_cnt_q[i] <= '0;
                end else begin
                    rpt_cnt_q[i] <= rpt_cnt_q[i] + RPT_W'(1);
                end
            end
        end
    end
`else
    assign evt_next_c = rise_c;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_next_c;
        end
    end

    // Priority encode directions; lockout discards rather than defers events.
    always_comb begin
        dir_next_c     = DIR_IDLE;
        confirm_next_c = 1'b0;
        if (!game_over) begin
            if (evt_q[KEY_UP]) begin
                dir_next_c = DIR_UP;
            end else if (evt_q[KEY_DOWN]) begin
                dir_next_c = DIR_DOWN;
            end else if (evt_q[KEY_RIGHT]) begin
                dir_next_c = DIR_RIGHT;
            end else if (evt_q[KEY_LEFT]) begin
                dir_next_c = DIR_LEFT;
            end
            confirm_next_c = evt_q[KEY_CONFIRM];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir     <= DIR_IDLE;
            confirm <= 1'b0;
        end else begin
            dir     <= dir_next_c;
            confirm <= confirm_next_c;
        end
    end

endmodule

// File: tb/tb_move_input_conditioner.sv
// Scoreboard bench for move_input_conditioner: directed scenarios plus random key/lockout/reset traffic.
module tb_move_input_conditioner;

    localparam int DEB = 4;
    localparam int RPT = 8;

    logic       clk;
    logic       reset;
    logic       key_up, key_down, key_right, key_left, key_confirm;
    logic       game_over;
    logic [2:0] dir;
    logic       confirm;

    move_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_CYCLES  (RPT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_up     (key_up),
        .key_down   (key_down),
        .key_right  (key_right),
        .key_left   (key_left),
        .key_confirm(key_confirm),
        .game_over  (game_over),
        .dir        (dir),
        .confirm    (confirm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         at_edge;
        logic [2:0] dir;
        logic       conf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_x;
    int   errors  = 0;
    int   checks  = 0;
    int   edge_no = 0;

    // Reference model state, indexed up, down, right, left, confirm.
    logic m_stable [5];
    int   m_run    [5];
    int   m_due    [5];

    // Model rule: a key is accepted after DEB consecutive edge samples at a new level;
    // a press shows on the outputs 3 edges after the last of those samples.
    task automatic model_step(input int e, input logic [4:0] keys, input logic go, input logic rst);
        logic [4:0] fire;
        logic [2:0] d;
        logic       c;
        if (rst) begin
            for (int k = 0; k < 5; k++) begin
                m_stable[k] = 1'b0;
                m_run[k]    = 0;
                m_due[k]    = -1;
            end
            return;
        end
        fire = '0;
        for (int k = 0; k < 5; k++) begin
            if (m_due[k] == e) begin
                fire[k]  = 1'b1;
                m_due[k] = -1;
`ifdef MOVE_INPUT_AUTO_REPEAT_EN
                if (k < 4 && m_stable[k]) m_due[k] = e + RPT;
`endif
            end
        end
        d = 3'd0;
        if (fire[0])      d = 3'd1;
        else if (fire[1]) d = 3'd2;
        else if (fire[2]) d = 3'd3;
        else if (fire[3]) d = 3'd4;
        c = fire[4];
        if (go) begin
            d = 3'd0;
            c = 1'b0;
        end
        if (d != 3'd0 || c) exp_q.push_back('{e, d, c});
        for (int k = 0; k < 5; k++) begin
            if (keys[k] != m_stable[k]) begin
                m_run[k]++;
                if (m_run[k] == DEB) begin
                    m_stable[k] = ~m_stable[k];
                    m_run[k]    = 0;
                    if (m_stable[k]) m_due[k] = e + 3;
                    else if (m_due[k] > e + 3) m_due[k] = -1;
                end
            end else begin
                m_run[k] = 0;
            end
        end
    endtask

    task automatic drive(input logic [4:0] k, input logic go, input logic rst);
        @(negedge clk);
        {key_confirm, key_left, key_right, key_down, key_up} = k;
        game_over = go;
        reset     = rst;
        model_step(edge_no + 1, k, go, rst);
    endtask

    task automatic drive_n(input int n, input logic [4:0] k, input logic go);
        for (int i = 0; i < n; i++) drive(k, go, 1'b0);
    endtask

    // Monitor: pops an expectation when one is due, otherwise any output activity is unexpected.
    always begin
        @(posedge clk);
        #1;
        edge_no++;
        if (exp_q.size() != 0 && exp_q[0].at_edge == edge_no) begin
            mon_x = exp_q.pop_front();
            checks++;
            if (dir !== mon_x.dir || confirm !== mon_x.conf) begin
                errors++;
                $display("FAIL pulse@%0d: got dir=%b confirm=%b, want dir=%b confirm=%b",
                         edge_no, dir, confirm, mon_x.dir, mon_x.conf);
            end
        end else if (dir !== 3'b000 || confirm !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle@%0d: got dir=%b confirm=%b, want dir=000 confirm=0",
                     edge_no, dir, confirm);
        end
    end

    logic [4:0] lvl;
    int         hold [5];
    logic       go_r;
    int         go_hold;

    initial begin
        for (int k = 0; k < 5; k++) begin
            m_stable[k] = 1'b0;
            m_run[k]    = 0;
            m_due[k]    = -1;
            hold[k]     = 0;
        end
        reset = 1'b1;
        {key_confirm, key_left, key_right, key_down, key_up} = '0;
        game_over = 1'b0;
        #1;
        checks++;
        if (dir !== 3'b000 || confirm !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got dir=%b confirm=%b, want 000/0", dir, confirm);
        end
        for (int i = 0; i < 3; i++) drive('0, 1'b0, 1'b1);
        drive_n(5, 5'b00000, 1'b0);

        // Right held: single 011 pulse, nothing on release.
        drive_n(20, 5'b00100, 1'b0);
        drive_n(10, 5'b00000, 1'b0);
        // Up for 3 cycles only: filtered out.
        drive_n(3, 5'b00001, 1'b0);
        drive_n(10, 5'b00000, 1'b0);
        // Down and left together: down wins, left discarded.
        drive_n(15, 5'b01010, 1'b0);
        drive_n(10, 5'b00000, 1'b0);
        // Confirm pressed during lockout, lockout lifted while still held.
        drive_n(20, 5'b10000, 1'b1);
        drive_n(10, 5'b10000, 1'b0);
        drive_n(10, 5'b00000, 1'b0);
        // Reset two cycles into a left debounce, released with left held.
        drive_n(2, 5'b01000, 1'b0);
        drive(5'b01000, 1'b0, 1'b1);
        drive(5'b01000, 1'b0, 1'b1);
        drive_n(15, 5'b01000, 1'b0);
        drive_n(10, 5'b00000, 1'b0);
        // Confirm and right together: both outputs in the same cycle.
        drive_n(12, 5'b10100, 1'b0);
        drive_n(10, 5'b00000, 1'b0);
        // Bouncy up press that eventually settles.
        drive_n(2, 5'b00001, 1'b0);
        drive_n(1, 5'b00000, 1'b0);
        drive_n(3, 5'b00001, 1'b0);
        drive_n(1, 5'b00000, 1'b0);
        drive_n(12, 5'b00001, 1'b0);
        drive_n(10, 5'b00000, 1'b0);

        // Reset asserted while a right pulse is on the output must clear it immediately.
        drive_n(7, 5'b00100, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        model_step(edge_no + 1, 5'b00100, 1'b0, 1'b1);
        #1;
        checks++;
        if (dir !== 3'b000 || confirm !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got dir=%b confirm=%b, want 000/0", dir, confirm);
        end
        drive(5'b00000, 1'b0, 1'b1);
        drive_n(10, 5'b00000, 1'b0);

        // Random traffic: mixes glitches, long holds, lockout windows and rare resets.
        lvl     = '0;
        go_r    = 1'b0;
        go_hold = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            for (int k = 0; k < 5; k++) begin
                if (hold[k] == 0) begin
                    lvl[k]  = 1'($urandom_range(0, 1));
                    hold[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(4, 20));
                end
                hold[k]--;
            end
            if (go_hold == 0) begin
                go_r    = ($urandom_range(0, 4) == 0);
                go_hold = int'($urandom_range(1, 30));
            end
            go_hold--;
            drive(lvl, go_r, ($urandom_range(0, 299) == 0));
        end

        drive_n(20, 5'b00000, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding expected pulses, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
